fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low; all state cleared while low.
REQ-004 stall  input  1  IF/ID register hold from hazard unit; instruction not consumed this cycle.
REQ-005 redirect  input  1  branch/jump taken; discard current fetch.
REQ-006 redirect_pc  input  32  new fetch address, valid with redirect.
REQ-007 imem_req  output  1  request valid to instruction memory.
REQ-008 imem_addr  output  32  request address, word aligned.
REQ-009 imem_gnt  input  1  memory accepts request this cycle.
REQ-010 imem_rvalid  input  1  response data valid this cycle.
REQ-011 imem_rdata  input  32  response instruction word.
REQ-012 valid_f  output  1  instr_f/pc_f hold a valid fetched instruction.
REQ-013 instr_f  output  32  fetched instruction to IF/ID register.
REQ-014 pc_f  output  32  address of instr_f.
REQ-015 pcplus4_f  output  32  pc_f + 4.

Function
REQ-016 States SHALL be REQ, WAIT, HOLD, plus 1-bit drop flag; at most one request outstanding.
REQ-017 REQ: imem_req=1, imem_addr=pc; gnt -> WAIT; no gnt -> stay REQ, address stable.
REQ-018 WAIT: imem_req=0; rvalid with drop=0 -> latch imem_rdata into instr buffer, -> HOLD.
REQ-019 WAIT: rvalid with drop=1 -> discard data, clear drop, -> REQ.
REQ-020 HOLD: valid_f=1, instr_f=buffer, pc_f=pc; stall=1 -> stay HOLD, outputs unchanged.
REQ-021 HOLD with stall=0: instruction consumed; pc <= pc+4; imem_req=1, imem_addr=pc+4 same cycle; gnt -> WAIT, else -> REQ.
REQ-022 valid_f SHALL be 0 in REQ and WAIT; instr_f holds last buffer value.
REQ-023 pcplus4_f and pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 redirect SHALL override stall and all transitions: pc <= redirect_pc, valid_f=0 and imem_req=0 that cycle.
REQ-025 redirect in REQ or HOLD -> next state REQ, drop unchanged.
REQ-026 redirect in WAIT without rvalid -> set drop=1, stay WAIT; redirect in WAIT with rvalid -> data discarded, drop=0, -> REQ.
REQ-027 Repeated redirects before the drop response SHALL only update pc; one response discarded.
REQ-028 imem_rvalid in REQ or HOLD is a protocol violation and SHALL be ignored.
REQ-029 Latency: gnt cycle N, rvalid cycle N+k (k>=1) -> valid_f=1 from cycle N+k+1.

Reset
REQ-030 While reset=0: state REQ, pc=RESET_PC, drop=0, instr buffer=0, valid_f=0, imem_req=0.
REQ-031 First cycle after release: imem_req=1, imem_addr=RESET_PC.
REQ-032 Reset asserted mid-WAIT SHALL abandon the request; late rvalid after release ignored per REQ-028.

Verification
REQ-033 Reset release, gnt immediate, rvalid next cycle data 32'h2002_0001 -> valid_f=1, instr_f=32'h2002_0001, pc_f=0, pcplus4_f=4.
REQ-034 Three back-to-back fetches, stall=0, 1-cycle memory -> pc_f 0,4,8 each presented exactly once.
REQ-035 HOLD with stall=1 for 4 cycles -> outputs constant, imem_req=0; stall release -> imem_addr=pc+4.
REQ-036 redirect to 32'h0000_0100 while WAIT, rvalid 2 cycles later -> data discarded, next imem_addr=32'h100, valid_f stays 0 until its response.
REQ-037 RESET_PC=32'hFFFF_FFFC -> pcplus4_f=0, next imem_addr=0.
REQ-038 redirect and stall together in HOLD -> redirect wins, next cycle imem_req=1 with redirect_pc.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Instruction fetch unit: single-outstanding imem requester feeding the IF/ID register
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        valid_f,
    output logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] pcplus4_f
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic        drop_q, drop_d;
    logic        req_c;
    logic        valid_c;
    logic [31:0] addr_c;
    logic [31:0] pc_next;

    assign pc_next = pc_q + 32'd4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            buf_q   <= 32'h0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        drop_d  = drop_q;
        req_c   = 1'b0;
        valid_c = 1'b0;
        addr_c  = pc_q;

        case (state_q)
            S_REQ: begin
                req_c = 1'b1;
                if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        buf_d   = imem_rdata;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                valid_c = 1'b1;
                if (!stall) begin
                    // Consume and issue the next sequential fetch in the same cycle.
                    pc_d    = pc_next;
                    req_c   = 1'b1;
                    addr_c  = pc_next;
                    state_d = imem_gnt ? S_WAIT : S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        // Redirect beats stall and every other transition; an in-flight response is dropped.
        if (redirect) begin
            req_c   = 1'b0;
            valid_c = 1'b0;
            pc_d    = {redirect_pc[31:2], 2'b00};
            buf_d   = buf_q;
            if (state_q == S_WAIT) begin
                if (imem_rvalid) begin
                    drop_d  = 1'b0;
                    state_d = S_REQ;
                end else begin
                    drop_d  = 1'b1;
                    state_d = S_WAIT;
                end
            end else begin
                drop_d  = drop_q;
                state_d = S_REQ;
            end
        end
    end

    assign imem_req  = req_c & reset;
    assign imem_addr = {addr_c[31:2], 2'b00};
    assign valid_f   = valid_c & reset;
    assign instr_f   = buf_q;
    assign pc_f      = pc_q;
    assign pcplus4_f = pc_next;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - Table-driven and sequence checks for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, redirect, imem_gnt, imem_rvalid;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, valid_f;
    logic [31:0] imem_addr, instr_f, pc_f, pcplus4_f;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc, w_pcp4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .valid_f(valid_f), .instr_f(instr_f), .pc_f(pc_f), .pcplus4_f(pcplus4_f)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .valid_f(w_valid), .instr_f(w_instr), .pc_f(w_pc), .pcplus4_f(w_pcp4)
    );

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NV = 30;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp, input logic g,
                                input logic v, input logic [31:0] d, input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ei, input logic [31:0] ep);
        vec_t t;
        t.stall = s; t.redir = r; t.rpc = rp; t.gnt = g; t.rv = v; t.rdata = d;
        t.e_req = er; t.e_addr = ea; t.e_valid = ev; t.e_instr = ei; t.e_pc = ep;
        return t;
    endfunction

    task automatic drive(input logic s, input logic r, input logic [31:0] rp, input logic g,
                         input logic v, input logic [31:0] d);
        @(negedge clk);
        stall = s; redirect = r; redirect_pc = rp; imem_gnt = g; imem_rvalid = v; imem_rdata = d;
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        //         stl red rpc           gnt rv  rdata          req addr          vld instr          pc
        tbl[0]  = mk(0, 0, 32'h0,        1, 0, 32'h0,          1, 32'h0,        0, 32'h0,          32'h0);
        tbl[1]  = mk(0, 0, 32'h0,        0, 1, 32'h2002_0001,  0, 32'h0,        0, 32'h0,          32'h0);
        tbl[2]  = mk(0, 0, 32'h0,        1, 0, 32'h0,          1, 32'h4,        1, 32'h2002_0001,  32'h0);
        tbl[3]  = mk(0, 0, 32'h0,        0, 1, 32'h1111_0004,  0, 32'h0,        0, 32'h2002_0001,  32'h4);
        tbl[4]  = mk(0, 0, 32'h0,        1, 0, 32'h0,          1, 32'h8,        1, 32'h1111_0004,  32'h4);
        tbl[5]  = mk(0, 0, 32'h0,        0, 1, 32'h2222_0008,  0, 32'h0,        0, 32'h1111_0004,  32'h8);
        tbl[6]  = mk(1, 0, 32'h0,        0, 0, 32'h0,          0, 32'h0,        1, 32'h2222_0008,  32'h8);
        tbl[7]  = mk(1, 0, 32'h0,        0, 0, 32'h0,          0, 32'h0,        1, 32'h2222_0008,  32'h8);
        tbl[8]  = mk(1, 0, 32'h0,        0, 0, 32'h0,          0, 32'h0,        1, 32'h2222_0008,  32'h8);
        tbl[9]  = mk(1, 0, 32'h0,        0, 0, 32'h0,          0, 32'h0,        1, 32'h2222_0008,  32'h8);
        tbl[10] = mk(0, 0, 32'h0,        0, 0, 32'h0,          1, 32'hC,        1, 32'h2222_0008,  32'h8);
        tbl[11] = mk(0, 0, 32'h0,        0, 0, 32'h0,          1, 32'hC,        0, 32'h2222_0008,  32'hC);
        tbl[12] = mk(0, 0, 32'h0,        1, 0, 32'h0,          1, 32'hC,        0, 32'h2222_0008,  32'hC);
        tbl[13] = mk(0, 1, 32'h100,      0, 0, 32'h0,          0, 32'h0,        0, 32'h2222_0008,  32'hC);
        tbl[14] = mk(0, 0, 32'h0,        0, 0, 32'h0,          0, 32'h0,        0, 32'h2222_0008,  32'h100);
        tbl[15] = mk(0, 0, 32'h0,        0, 1, 32'hDEAD_BEEF,  0, 32'h0,        0, 32'h2222_0008,  32'h100);
        tbl[16] = mk(0, 0, 32'h0,        0, 0, 32'h0,          1, 32'h100,      0, 32'h2222_0008,  32'h100);
        tbl[17] = mk(0, 0, 32'h0,        1, 0, 32'h0,          1, 32'h100,      0, 32'h2222_0008,  32'h100);
        tbl[18] = mk(0, 0, 32'h0,        0, 1, 32'h3333_0100,  0, 32'h0,        0, 32'h2222_0008,  32'h100);
        tbl[19] = mk(1, 1, 32'h200,      0, 0, 32'h0,          0, 32'h0,        0, 32'h3333_0100,  32'h100);
        tbl[20] = mk(0, 0, 32'h0,        1, 0, 32'h0,          1, 32'h200,      0, 32'h3333_0100,  32'h200);
        tbl[21] = mk(0, 1, 32'h300,      0, 1, 32'h4444_0200,  0, 32'h0,        0, 32'h3333_0100,  32'h200);
        tbl[22] = mk(0, 0, 32'h0,        1, 1, 32'h5555_0300,  1, 32'h300,      0, 32'h3333_0100,  32'h300);
        tbl[23] = mk(0, 1, 32'h400,      0, 0, 32'h0,          0, 32'h0,        0, 32'h3333_0100,  32'h300);
        tbl[24] = mk(0, 1, 32'h500,      0, 0, 32'h0,          0, 32'h0,        0, 32'h3333_0100,  32'h400);
        tbl[25] = mk(0, 0, 32'h0,        0, 1, 32'h6666_0400,  0, 32'h0,        0, 32'h3333_0100,  32'h500);
        tbl[26] = mk(0, 0, 32'h0,        1, 0, 32'h0,          1, 32'h500,      0, 32'h3333_0100,  32'h500);
        tbl[27] = mk(0, 0, 32'h0,        0, 1, 32'h7777_0500,  0, 32'h0,        0, 32'h3333_0100,  32'h500);
        tbl[28] = mk(1, 0, 32'h0,        0, 1, 32'h8888_0000,  0, 32'h0,        1, 32'h7777_0500,  32'h500);
        tbl[29] = mk(1, 0, 32'h0,        0, 0, 32'h0,          0, 32'h0,        1, 32'h7777_0500,  32'h500);

        reset = 1'b0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", valid_f, 1'b0);
        check("rst_pc", pc_f, 32'h0);
        check("rst_instr", instr_f, 32'h0);
        check("rst_wrap_req", w_req, 1'b0);

        // First fetch after release; the wrap instance starts at the top of the address space.
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rel_req", imem_req, 1'b1);
        check("rel_addr", imem_addr, 32'h0);
        check("rel_wrap_addr", w_addr, 32'hFFFF_FFFC);
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        check("wrap_req_gnt", w_req, 1'b1);
        drive(0, 0, 32'h0, 0, 1, 32'h2002_0001);
        check("first_wait_valid", valid_f, 1'b0);
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        check("first_valid", valid_f, 1'b1);
        check("first_instr", instr_f, 32'h2002_0001);
        check("first_pc", pc_f, 32'h0);
        check("first_pcp4", pcplus4_f, 32'h4);
        check("wrap_valid", w_valid, 1'b1);
        check("wrap_pc", w_pc, 32'hFFFF_FFFC);
        check("wrap_pcp4", w_pcp4, 32'h0);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        check("wrap_next_req", w_req, 1'b1);
        check("wrap_next_addr", w_addr, 32'h0);

        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].stall, tbl[i].redir, tbl[i].rpc, tbl[i].gnt, tbl[i].rv, tbl[i].rdata);
            check($sformatf("v%0d_req", i), imem_req, tbl[i].e_req);
            if (tbl[i].e_req)
                check($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_addr);
            check($sformatf("v%0d_valid", i), valid_f, tbl[i].e_valid);
            check($sformatf("v%0d_instr", i), instr_f, tbl[i].e_instr);
            check($sformatf("v%0d_pc", i), pc_f, tbl[i].e_pc);
            check($sformatf("v%0d_pcp4", i), pcplus4_f, tbl[i].e_pc + 32'd4);
        end

        // Reset in the middle of WAIT abandons the request; the stale response is ignored in REQ.
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        check("mw_req", imem_req, 1'b1);
        check("mw_addr", imem_addr, 32'h504);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        check("mw_rst_req", imem_req, 1'b0);
        check("mw_rst_pc", pc_f, 32'h0);
        check("mw_rst_instr", instr_f, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 32'h0, 0, 1, 32'h9999_0504);
        check("mw_late_req", imem_req, 1'b1);
        check("mw_late_addr", imem_addr, 32'h0);
        check("mw_late_instr", instr_f, 32'h0);
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        check("mw_refetch_req", imem_req, 1'b1);
        drive(0, 0, 32'h0, 0, 1, 32'hABCD_0000);
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        check("mw_final_valid", valid_f, 1'b1);
        check("mw_final_instr", instr_f, 32'hABCD_0000);
        check("mw_final_pc", pc_f, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
